// File: rtl/neuron_sched_pkg.sv
// Shared types and constants for the time-multiplexed neuron update scheduler.
package neuron_sched_pkg;
   localparam int                FP_W              = 32;
   localparam logic [FP_W-1:0]   THRESHOLD_DEFAULT = 32'h4287c7ae;
   localparam logic [FP_W-1:0]   FP_ZERO           = '0;

   typedef enum logic [1:0] {
      ST_CONFIG,
      ST_IDLE,
      ST_EVT_ISSUE,
      ST_DECAY
   } sched_state_e;
endpackage

// File: rtl/neuron_update_scheduler_fp_halve.sv
// Combinational IEEE-754 single halving by exponent decrement; tiny values flush to +0.
module fp_halve
   import neuron_sched_pkg::*;
(
   input  logic [FP_W-1:0] din,
   output logic [FP_W-1:0] dout
);
   logic [7:0] exp_f;

   assign exp_f = din[30:23];

   // Inf/NaN pass through untouched; exponent 0/1 would become subnormal, so flush.
   always_comb begin
      dout = din;
      if (exp_f == 8'hFF)
         dout = din;
      else if (exp_f <= 8'd1)
         dout = FP_ZERO;
      else
         dout = {din[31], exp_f - 8'd1, din[22:0]};
   end
endmodule

// File: rtl/neuron_update_scheduler.sv
// Schedules weight events and timestep decay sweeps over a shared external potential adder.
module neuron_update_scheduler
   import neuron_sched_pkg::*;
#(
   parameter int NUM_NEURONS = 16,
   parameter int ID_W        = $clog2(NUM_NEURONS)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              timestep_start,
   input  logic              evt_valid,
   output logic              evt_ready,
   input  logic [ID_W-1:0]   evt_neuron_id,
   input  logic [FP_W-1:0]   evt_weight,
   output logic [FP_W-1:0]   adder_input_weight,
   output logic [FP_W-1:0]   adder_decayed_potential,
   output logic              adder_clear,
   output logic              adder_set,
   input  logic [FP_W-1:0]   adder_final_potential,
   input  logic              adder_spike,
   output logic              spike_valid,
   output logic [ID_W-1:0]   spike_neuron_id,
   output logic              sweep_done,
   output logic              ts_overrun,
   input  logic [ID_W-1:0]   pot_rd_addr,
   output logic [FP_W-1:0]   pot_rd_data
);
   sched_state_e    state, state_nxt;
   logic [FP_W-1:0] pot [NUM_NEURONS];
   logic            pending;
   logic [ID_W-1:0] sweep_idx;
   logic [ID_W-1:0] lat_id;
   logic [FP_W-1:0] lat_w;
   logic [FP_W-1:0] halved;
   logic            sweep_last;
   logic            issue_spike;

   assign sweep_last  = (sweep_idx == ID_W'(NUM_NEURONS-1));
   assign issue_spike = (state == ST_EVT_ISSUE) && adder_spike;
   assign pot_rd_data = pot[pot_rd_addr];

   fp_halve u_halve (
      .din  (pot[sweep_idx]),
      .dout (halved)
   );

   // adder_set is gated by rst_n so it stays low while reset is held in CONFIG.
   always_comb begin
      state_nxt               = state;
      evt_ready               = 1'b0;
      adder_set               = 1'b0;
      adder_clear             = 1'b0;
      adder_input_weight      = FP_ZERO;
      adder_decayed_potential = FP_ZERO;
      case (state)
         ST_CONFIG: begin
            adder_set   = rst_n;
            adder_clear = 1'b1;
            state_nxt   = ST_IDLE;
         end
         ST_IDLE: begin
            evt_ready = ~pending;
            if (pending)
               state_nxt = ST_DECAY;
            else if (evt_valid)
               state_nxt = ST_EVT_ISSUE;
         end
         ST_EVT_ISSUE: begin
            adder_input_weight      = lat_w;
            adder_decayed_potential = pot[lat_id];
            state_nxt               = ST_IDLE;
         end
         ST_DECAY: begin
            adder_clear = 1'b1;
            if (sweep_last)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_CONFIG;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_CONFIG;
         pending         <= 1'b0;
         ts_overrun      <= 1'b0;
         sweep_idx       <= '0;
         lat_id          <= '0;
         lat_w           <= FP_ZERO;
         spike_valid     <= 1'b0;
         spike_neuron_id <= '0;
         sweep_done      <= 1'b0;
      end else begin
         state       <= state_nxt;
         spike_valid <= issue_spike;
         sweep_done  <= (state == ST_DECAY) && sweep_last;
         if (issue_spike)
            spike_neuron_id <= lat_id;
         if (evt_valid && evt_ready) begin
            lat_id <= evt_neuron_id;
            lat_w  <= evt_weight;
         end
         if (state == ST_DECAY)
            sweep_idx <= sweep_last ? '0 : sweep_idx + ID_W'(1);
         if (state == ST_DECAY && sweep_last)
            pending <= 1'b0;
         // Only one sweep may be queued; anything beyond that is dropped and flagged.
         if (timestep_start) begin
            if (pending || state == ST_DECAY)
               ts_overrun <= 1'b1;
            else if (state == ST_IDLE || state == ST_EVT_ISSUE)
               pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++)
            pot[i] <= FP_ZERO;
      end else if (state == ST_EVT_ISSUE) begin
         pot[lat_id] <= adder_final_potential;
      end else if (state == ST_DECAY) begin
         pot[sweep_idx] <= halved;
      end
   end
endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Scoreboard bench: stimulus queues expected spikes/sweeps, a negedge monitor pops and checks them.
module tb_neuron_update_scheduler;
   import neuron_sched_pkg::*;

   localparam int N  = 16;
   localparam int IW = 4;
   localparam logic [31:0] W_A = 32'h42470A3D;
   localparam logic [31:0] W_B = 32'h42C70A3D;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          timestep_start = 1'b0;
   logic          evt_valid = 1'b0;
   logic          evt_ready;
   logic [IW-1:0] evt_neuron_id = '0;
   logic [31:0]   evt_weight = '0;
   logic [31:0]   adder_input_weight, adder_decayed_potential;
   logic          adder_clear, adder_set;
   logic [31:0]   adder_final_potential;
   logic          adder_spike;
   logic          spike_valid;
   logic [IW-1:0] spike_neuron_id;
   logic          sweep_done, ts_overrun;
   logic [IW-1:0] pot_rd_addr = '0;
   logic [31:0]   pot_rd_data;

   typedef struct { logic [IW-1:0] id; int cyc; } spk_t;
   spk_t spk_q[$];
   int   swp_q[$];
   spk_t mon_e;
   int   n_chk = 0, n_fail = 0, cyc = 0, dcnt = 0, acc_cyc = 0, last_acc = 0;

   always #5 clk = ~clk;

   neuron_update_scheduler #(.NUM_NEURONS(N)) dut (
      .clk(clk), .rst_n(rst_n), .timestep_start(timestep_start),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_neuron_id(evt_neuron_id), .evt_weight(evt_weight),
      .adder_input_weight(adder_input_weight),
      .adder_decayed_potential(adder_decayed_potential),
      .adder_clear(adder_clear), .adder_set(adder_set),
      .adder_final_potential(adder_final_potential), .adder_spike(adder_spike),
      .spike_valid(spike_valid), .spike_neuron_id(spike_neuron_id),
      .sweep_done(sweep_done), .ts_overrun(ts_overrun),
      .pot_rd_addr(pot_rd_addr), .pot_rd_data(pot_rd_data)
   );

   // Hand-computed adder results; an unexpected operand pair yields a poison value.
   function automatic logic [32:0] adder_model(input logic [31:0] w, input logic [31:0] p);
      if (p == FP_ZERO) return {1'b0, w};
      case ({w, p})
         {W_A, W_A}:          return {1'b1, 32'h41FD0A3D};  // 99.52 > 67.89 -> 31.63
         {W_B, 32'h40FD0A3D}: return {1'b1, 32'h421E28F6};  // 107.43 > 67.89 -> 39.54
         default:             return {1'b0, 32'hBAD0BAD0};
      endcase
   endfunction

   always_comb {adder_spike, adder_final_potential} = adder_model(adder_input_weight, adder_decayed_potential);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic rd_chk(input logic [IW-1:0] a, input logic [31:0] exp, input string nm);
      pot_rd_addr = a;
      #1;
      chk(nm, pot_rd_data, exp);
   endtask

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic send_evt(input logic [IW-1:0] id, input logic [31:0] w,
                           input bit spk, input bit hold, input bit gap_chk);
      int t;
      t = 0;
      evt_valid = 1'b1; evt_neuron_id = id; evt_weight = w;
      while (!evt_ready && t < 50) begin @(negedge clk); t++; end
      if (!evt_ready) chk("evt_accept_timeout", {31'd0, evt_ready}, 32'd1);
      @(negedge clk);
      acc_cyc = cyc;
      if (gap_chk) chk("evt_throughput_gap", acc_cyc - last_acc, 32'd2);
      last_acc = acc_cyc;
      if (spk) spk_q.push_back('{id, acc_cyc + 1});
      if (!hold) evt_valid = 1'b0;
   endtask

   task automatic wait_sweep(input string nm);
      int t;
      t = 0;
      while (!sweep_done && t < 60) begin @(negedge clk); t++; end
      chk(nm, {31'd0, sweep_done}, 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_evt_ready"},   {31'd0, evt_ready},   32'd0);
      chk({nm, "_spike_valid"}, {31'd0, spike_valid}, 32'd0);
      chk({nm, "_spike_id"},    {28'd0, spike_neuron_id}, 32'd0);
      chk({nm, "_sweep_done"},  {31'd0, sweep_done},  32'd0);
      chk({nm, "_ts_overrun"},  {31'd0, ts_overrun},  32'd0);
      chk({nm, "_adder_set"},   {31'd0, adder_set},   32'd0);
      chk({nm, "_adder_clear"}, {31'd0, adder_clear}, 32'd1);
      chk({nm, "_op_w"},        adder_input_weight,      32'd0);
      chk({nm, "_op_p"},        adder_decayed_potential, 32'd0);
   endtask

   initial forever @(posedge clk) cyc++;

   // Monitor: pops expectations whenever the DUT presents a spike or sweep completion.
   initial forever begin
      @(negedge clk);
      if (!rst_n) dcnt = 0;
      else begin
         if (spike_valid) begin
            chk("spike_expected", {31'd0, spk_q.size() != 0}, 32'd1);
            if (spk_q.size() != 0) begin
               mon_e = spk_q.pop_front();
               chk("spike_id", {28'd0, spike_neuron_id}, {28'd0, mon_e.id});
               chk("spike_cycle", cyc, mon_e.cyc);
               chk("spike_not_in_decay", {31'd0, adder_clear}, 32'd0);
            end
         end
         if (adder_clear && !adder_set) begin
            dcnt++;
            chk("evt_ready_in_decay", {31'd0, evt_ready}, 32'd0);
         end
         if (sweep_done) begin
            chk("sweep_expected", {31'd0, swp_q.size() != 0}, 32'd1);
            if (swp_q.size() != 0) begin
               void'(swp_q.pop_front());
               chk("decay_cycles", dcnt, 32'd16);
            end
            dcnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset and CONFIG
      repeat (3) @(negedge clk);
      chk_reset_outs("rst");
      rst_n = 1'b1;
      #1;
      chk("config_adder_set", {31'd0, adder_set}, 32'd1);
      chk("config_evt_ready", {31'd0, evt_ready}, 32'd0);
      @(negedge clk);
      chk("idle_adder_set", {31'd0, adder_set}, 32'd0);
      chk("idle_adder_clear", {31'd0, adder_clear}, 32'd0);
      chk("idle_evt_ready", {31'd0, evt_ready}, 32'd1);
      for (int i = 0; i < N; i++) rd_chk(IW'(i), 32'h0, "pot_after_reset");
      @(negedge clk);

      // First event: potential 0 -> weight, no spike
      send_evt(4'd3, W_A, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rd_chk(4'd3, W_A, "pot3_first_evt");
      @(negedge clk);

      // Repeat: crosses threshold, spike with reset potential
      send_evt(4'd3, W_A, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rd_chk(4'd3, 32'h41FD0A3D, "pot3_after_spike");
      @(negedge clk);

      // Back-to-back burst loading decay boundary values
      send_evt(4'd5,  W_A,          1'b0, 1'b1, 1'b0);
      send_evt(4'd7,  32'h7F800001, 1'b0, 1'b1, 1'b1);
      send_evt(4'd9,  32'h00800001, 1'b0, 1'b1, 1'b1);
      send_evt(4'd10, 32'h80FFFFFF, 1'b0, 1'b1, 1'b1);
      send_evt(4'd11, 32'hC1000000, 1'b0, 1'b1, 1'b1);
      send_evt(4'd12, 32'h01000000, 1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      rd_chk(4'd5,  W_A,          "pot5_burst");
      rd_chk(4'd12, 32'h01000000, "pot12_burst");
      @(negedge clk);

      // Decay sweep
      swp_q.push_back(1);
      timestep_start = 1'b1; @(negedge clk); timestep_start = 1'b0;
      wait_sweep("sweep1_done");
      rd_chk(4'd3,  32'h417D0A3D, "decay_pot3");
      rd_chk(4'd5,  32'h41C70A3D, "decay_pot5");
      rd_chk(4'd7,  32'h7F800001, "decay_exp255");
      rd_chk(4'd9,  32'h00000000, "decay_exp1");
      rd_chk(4'd10, 32'h00000000, "decay_exp1_neg");
      rd_chk(4'd11, 32'hC0800000, "decay_neg");
      rd_chk(4'd12, 32'h00800000, "decay_exp2");
      rd_chk(4'd0,  32'h00000000, "decay_zero");
      chk("no_overrun_yet", {31'd0, ts_overrun}, 32'd0);
      @(negedge clk);

      // Overrun: second pulse while pending, third during DECAY; one sweep only
      swp_q.push_back(2);
      timestep_start = 1'b1; repeat (2) @(negedge clk); timestep_start = 1'b0;
      repeat (4) @(negedge clk);
      timestep_start = 1'b1; @(negedge clk); timestep_start = 1'b0;
      wait_sweep("sweep2_done");
      repeat (25) @(negedge clk);
      chk("ts_overrun_set", {31'd0, ts_overrun}, 32'd1);
      chk("single_sweep", swp_q.size(), 32'd0);
      rd_chk(4'd5,  32'h41470A3D, "decay2_pot5");
      rd_chk(4'd12, 32'h00000000, "decay2_exp1");
      @(negedge clk);

      // Spiking event with timestep in the accept cycle: spike precedes DECAY
      swp_q.push_back(3);
      timestep_start = 1'b1;
      send_evt(4'd3, W_B, 1'b1, 1'b0, 1'b0);
      timestep_start = 1'b0;
      wait_sweep("sweep3_done");
      rd_chk(4'd3,  32'h419E28F6, "decay3_pot3");
      rd_chk(4'd11, 32'hBF800000, "decay3_pot11");
      @(negedge clk);

      // Reset mid-sweep: sweep abandoned, state cleared
      timestep_start = 1'b1; @(negedge clk); timestep_start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) rd_chk(IW'(i), 32'h0, "pot_after_rst_mid");
      @(negedge clk);

      // Reset during EVT_ISSUE of a spiking event: no spike, no write
      send_evt(4'd3, W_A, 1'b0, 1'b0, 1'b0);
      send_evt(4'd3, W_A, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rd_chk(4'd3, 32'h0, "pot3_after_inflight_rst");
      chk("evt_ready_after_rst", {31'd0, evt_ready}, 32'd1);
      @(negedge clk);

      chk("spike_queue_empty", spk_q.size(), 32'd0);
      chk("sweep_queue_empty", swp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/neuron_update_scheduler.md
NEURON_UPDATE_SCHEDULER -- requirements
Module: neuron_update_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 16, number of time-multiplexed neurons; SHALL be a power of 2 and at least 2.
REQ-002 Parameter ID_W, default $clog2(NUM_NEURONS), neuron index width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 timestep_start  in  1  one-cycle pulse that requests a decay sweep.
REQ-006 evt_valid / evt_ready  in / out  1 / 1  weight-event handshake; an event transfers when both are high on a rising edge.
REQ-007 evt_neuron_id  in  ID_W  target neuron of the event.
REQ-008 evt_weight  in  32  IEEE-754 single weight.
REQ-009 adder_input_weight / adder_decayed_potential  out  32 / 32  operands to the shared potential adder.
REQ-010 adder_clear / adder_set  out  1 / 1  adder control strobes.
REQ-011 adder_final_potential / adder_spike  in  32 / 1  combinational adder results.
REQ-012 spike_valid / spike_neuron_id  out  1 / ID_W  one-cycle spike report.
REQ-013 sweep_done  out  1  one-cycle pulse when a decay sweep completes.
REQ-014 ts_overrun  out  1  sticky flag: a timestep_start was dropped.
REQ-015 pot_rd_addr / pot_rd_data  in / out  ID_W / 32  combinational debug read of the potential store.

Function
REQ-016 The block SHALL hold NUM_NEURONS 32-bit potentials, all reset to 32'h00000000.
REQ-017 FSM states SHALL be CONFIG, IDLE, EVT_ISSUE, DECAY.
- Reset enters CONFIG.
- CONFIG lasts exactly 1 cycle with adder_set=1, then goes to IDLE.
REQ-018 In all other states adder_set SHALL be 0. adder_clear SHALL be 1 in CONFIG and DECAY, and 0 otherwise.
REQ-019 evt_ready SHALL be 1 only in IDLE with no timestep_start pending.
REQ-020 On an accepted event, the FSM SHALL latch the id and weight and enter EVT_ISSUE for exactly 1 cycle.
REQ-021 In EVT_ISSUE the block SHALL drive:
- adder_input_weight = latched weight;
- adder_decayed_potential = potential[id].
REQ-022 On the EVT_ISSUE edge, potential[id] SHALL be written with adder_final_potential. If adder_spike=1, spike_valid=1 with spike_neuron_id=id in the following cycle.
REQ-023 Event throughput SHALL be 1 per 2 cycles. Spike latency SHALL be 2 cycles after the accept edge.
REQ-024 A timestep_start seen in IDLE or EVT_ISSUE SHALL set a 1-deep pending bit.
REQ-025 With pending set, IDLE SHALL enter DECAY, with priority over evt_valid.
REQ-026 DECAY SHALL visit neuron 0..NUM_NEURONS-1, one per cycle. Each potential SHALL be replaced by its half:
- exponent field > 1: exponent - 1, sign and mantissa unchanged;
- exponent field 0 or 1: +0 (32'h00000000);
- exponent field 255: unchanged.
REQ-027 After the last neuron, sweep_done SHALL pulse for 1 cycle, the pending bit SHALL be cleared, and the FSM SHALL return to IDLE.
REQ-028 A timestep_start arriving while DECAY is active, or while pending is already set, SHALL be dropped and SHALL set ts_overrun; ts_overrun clears only on reset.
REQ-029 spike_valid and sweep_done SHALL never be high in the same cycle as a DECAY write to the same neuron. A spike from the last event SHALL be reported before DECAY begins.
REQ-030 Adder outputs SHALL be ignored outside EVT_ISSUE. Operand outputs SHALL be 32'h0 when not in EVT_ISSUE.

Reset
REQ-031 While rst_n=0, outputs SHALL be:
- evt_ready=0, spike_valid=0, spike_neuron_id=0, sweep_done=0, ts_overrun=0;
- adder_set=0, adder_clear=1, operands 0.
REQ-032 Reset SHALL clear all potentials, the pending bit, the sweep index and any latched event. An in-flight event or sweep SHALL be abandoned with no spike reported.

Structure
REQ-033 Package neuron_sched_pkg SHALL hold:
- the FSM state enum;
- FP_W=32;
- THRESHOLD_DEFAULT=32'h4287c7ae;
- FP_ZERO.
REQ-034 The exponent-decrement decay SHALL be a combinational sub-module fp_halve (32 in, 32 out). The shared adder SHALL stay external.

Verification
REQ-035 Reset release: 1 cycle adder_set=1, then evt_ready=1; all pot_rd_data=0.
REQ-036 Event id 3, weight 32'h42470A3D, with potential 0: potential[3]=32'h42470A3D, no spike.
REQ-037 Repeat the REQ-036 event: adder_spike=1 (99.52 > 67.89). Required response:
- spike_valid on the 2nd cycle after accept, id 3;
- potential[3] = adder reset output (~31.63).
REQ-038 timestep_start with potential[5]=32'h42470A3D: DECAY lasts 16 cycles, potential[5]=32'h41C70A3D, sweep_done pulses once, evt_ready stays low throughout.
REQ-039 timestep_start during DECAY, and two pulses in IDLE before DECAY starts: exactly one sweep runs and ts_overrun=1.
REQ-040 Back-to-back evt_valid with an event in flight: evt_ready toggles, giving 1 transfer per 2 cycles and no lost events.
